// File: rtl/i2osp_req_scheduler.sv
// rtl/i2osp_req_scheduler.sv - round-robin scheduler sharing one I2OSP core between NREQ requesters
// Optional abort-on-timeout path is enabled by defining I2OSP_TIMEOUT_EN.
module i2osp_req_scheduler #(
  parameter int NREQ    = 2,
  parameter int WIDTH   = 2048,
  parameter int TIMEOUT = 4095
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_x,
  output logic [NREQ-1:0]       grant,
  output logic [WIDTH-1:0]      res_data,
  output logic [NREQ-1:0]       res_done,
  output logic [NREQ-1:0]       err,
  output logic                  core_reset,
  output logic                  core_ready,
  output logic [WIDTH-1:0]      core_x,
  input  logic                  core_valid,
  input  logic [WIDTH-1:0]      core_X
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

`ifdef I2OSP_TIMEOUT_EN
  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_DONE, S_ABORT} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_DONE} state_t;
`endif

  state_t          state;
  state_t          state_next;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   pick_idx;
  logic            pick_found;
  logic            valid_q;
  logic            valid_edge;

  // Only a fresh rising edge completes an op, so a valid left high by the previous op is ignored.
  assign valid_edge = core_valid & ~valid_q;

`ifdef I2OSP_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  logic [CW-1:0] cnt;
  logic          timeout_hit;

  assign timeout_hit = (cnt == CW'(TIMEOUT));
  assign core_reset  = reset | (state == S_ABORT);

  // Zero while idle/launching in, so during WAIT it equals the number of WAIT cycles elapsed.
  always_ff @(posedge clk) begin
    if (reset || state == S_IDLE) begin
      cnt <= '0;
    end else if (state == S_LAUNCH || state == S_WAIT) begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign core_reset     = reset;
`endif

  // First requesting index at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!pick_found && req[(int'(rr_ptr) + i) % NREQ]) begin
        pick_found = 1'b1;
        pick_idx   = PW'((int'(rr_ptr) + i) % NREQ);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    core_ready = 1'b0;
    case (state)
      S_IDLE: begin
        if (pick_found) state_next = S_LAUNCH;
      end
      S_LAUNCH: begin
        core_ready = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (valid_edge) state_next = S_DONE;
`ifdef I2OSP_TIMEOUT_EN
        else if (timeout_hit) state_next = S_ABORT;
`endif
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
`ifdef I2OSP_TIMEOUT_EN
      S_ABORT: begin
        state_next = S_IDLE;
      end
`endif
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grant    <= '0;
      res_data <= '0;
      res_done <= '0;
      err      <= '0;
      core_x   <= '0;
      rr_ptr   <= '0;
      valid_q  <= 1'b0;
    end else begin
      valid_q  <= core_valid;
      res_done <= '0;
      err      <= '0;
      case (state)
        S_IDLE: begin
          if (pick_found) begin
            grant  <= NREQ'(1) << pick_idx;
            core_x <= req_x[int'(pick_idx)*WIDTH +: WIDTH];
            rr_ptr <= PW'((int'(pick_idx) + 1) % NREQ);
          end
        end
        S_WAIT: begin
          if (valid_edge) res_data <= core_X;
`ifdef I2OSP_TIMEOUT_EN
          else if (timeout_hit) err <= grant;
`endif
        end
        S_DONE: begin
          res_done <= grant;
          grant    <= '0;
        end
`ifdef I2OSP_TIMEOUT_EN
        S_ABORT: begin
          grant <= '0;
        end
`endif
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2osp_req_scheduler.sv
// tb/tb_i2osp_req_scheduler.sv - scoreboard bench for i2osp_req_scheduler with a behavioural I2OSP core
module tb_i2osp_req_scheduler;
  localparam int NREQ = 2;
  localparam int W    = 32;
  localparam int TO   = 15;

  logic            clk = 1'b0;
  logic            reset;
  logic [NREQ-1:0] req;
  logic [NREQ*W-1:0] req_x;
  logic [NREQ-1:0] grant;
  logic [W-1:0]    res_data;
  logic [NREQ-1:0] res_done;
  logic [NREQ-1:0] err;
  logic            core_reset;
  logic            core_ready;
  logic [W-1:0]    core_x;
  logic            core_valid;
  logic [W-1:0]    core_X;

  i2osp_req_scheduler #(.NREQ(NREQ), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .req_x(req_x), .grant(grant),
    .res_data(res_data), .res_done(res_done), .err(err), .core_reset(core_reset),
    .core_ready(core_ready), .core_x(core_x), .core_valid(core_valid), .core_X(core_X)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] i2osp_model(input logic [W-1:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  typedef struct {
    logic [NREQ-1:0] g;
    logic [W-1:0]    x;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  task automatic push_exp(input logic [NREQ-1:0] g, input logic [W-1:0] x);
    exp_t e;
    e.g = g;
    e.x = x;
    sb.push_back(e);
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int done_cnt = 0, rdy_cnt = 0, err_cnt = 0;
  int done_cyc = 0, rdy_cyc = 0, err_cyc = 0;
  logic [NREQ-1:0] err_val = '0;
  logic            err_rst = 1'b0;
  logic [NREQ-1:0] prev_grant = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (core_ready) begin
        rdy_cnt++;
        rdy_cyc = cyc;
        if (sb.size() > 0) begin
          check_eq("launch_grant", 64'(grant), 64'(sb[0].g));
          check_eq("launch_core_x", 64'(core_x), 64'(sb[0].x));
        end
      end
      if (res_done != '0) begin
        done_cnt++;
        done_cyc = cyc;
        if (sb.size() == 0) begin
          check_eq("unexpected_done", 64'(res_done), 64'(0));
        end else begin
          mon_e = sb.pop_front();
          check_eq("done_onehot", 64'(res_done), 64'(mon_e.g));
          check_eq("res_data", 64'(res_data), 64'(i2osp_model(mon_e.x)));
          check_eq("grant_cleared_after_done", 64'(grant), 64'(0));
        end
      end
      if (err != '0) begin
        err_cnt++;
        err_cyc = cyc;
        err_val = err;
        err_rst = core_reset;
      end
      if (prev_grant != '0 && grant != '0 && grant != prev_grant)
        check_eq("grant_switched_mid_op", 64'(grant), 64'(prev_grant));
      prev_grant = grant;
    end
  end

  // Behavioural core: valid pulses lat cycles after the ready strobe, or is driven manually.
  int          lat = 3;
  int          cd = 0;
  bit          auto_mode = 1'b1;
  bit          hold_valid = 1'b0;
  bit          man_mode = 1'b0;
  logic        man_valid = 1'b0;
  logic [W-1:0] man_X = '0;
  logic [W-1:0] lx = '0;

  initial begin
    core_valid = 1'b0;
    core_X     = '0;
    forever begin
      @(negedge clk);
      if (man_mode) begin
        core_valid = man_valid;
        core_X     = man_X;
        cd         = 0;
      end else begin
        if (cd > 0) begin
          cd--;
          if (cd == 0) begin
            core_valid = 1'b1;
            core_X     = i2osp_model(lx);
          end
        end else if (core_valid && !hold_valid) begin
          core_valid = 1'b0;
        end
        if (core_ready && auto_mode) begin
          cd = lat;
          lx = core_x;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input int target, input string tag);
    for (int k = 0; k < 200 && done_cnt < target; k++) tick(1);
    if (done_cnt < target) check_eq(tag, 64'(done_cnt), 64'(target));
  endtask

  int t0, nd, e0, r0;

  initial begin
    reset = 1'b1;
    req   = '0;
    req_x = '0;
    tick(3);
    check_eq("rst_grant", 64'(grant), 64'(0));
    check_eq("rst_res_done", 64'(res_done), 64'(0));
    check_eq("rst_err", 64'(err), 64'(0));
    check_eq("rst_core_ready", 64'(core_ready), 64'(0));
    check_eq("rst_core_x", 64'(core_x), 64'(0));
    check_eq("rst_res_data", 64'(res_data), 64'(0));
    check_eq("rst_core_reset", 64'(core_reset), 64'(1));
    reset = 1'b0;
    #1;
    check_eq("core_reset_released", 64'(core_reset), 64'(0));

    // Single requester, latency and single ready strobe
    req_x[W-1:0] = 32'h0000_1234;
    push_exp(2'b01, 32'h0000_1234);
    t0 = cyc;
    r0 = rdy_cnt;
    req = 2'b01;
    wait_done(1, "t1_done_timeout");
    req = '0;
    check_eq("t1_latency", 64'(done_cyc - t0), 64'(6));
    check_eq("t1_ready_pulses", 64'(rdy_cnt - r0), 64'(1));

    // Both requesting continuously from a fresh round-robin pointer
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    req_x = {32'hB0B0_0002, 32'hA0A0_0001};
    push_exp(2'b01, 32'hA0A0_0001);
    push_exp(2'b10, 32'hB0B0_0002);
    push_exp(2'b01, 32'hA0A0_0001);
    push_exp(2'b10, 32'hB0B0_0002);
    nd = done_cnt;
    req = 2'b11;
    wait_done(nd + 4, "t2_done_timeout");
    req = '0;
    check_eq("t2_sb_drained", 64'(sb.size()), 64'(0));

    // Stale high valid must not complete the next op
    hold_valid = 1'b1;
    req_x[2*W-1:W] = 32'hC0DE_0003;
    push_exp(2'b10, 32'hC0DE_0003);
    nd = done_cnt;
    req = 2'b10;
    wait_done(nd + 1, "t3a_done_timeout");
    req = '0;
    man_valid = 1'b1;
    man_X = '0;
    man_mode = 1'b1;
    hold_valid = 1'b0;
    req_x[W-1:0] = 32'hD00D_0004;
    push_exp(2'b01, 32'hD00D_0004);
    nd = done_cnt;
    req = 2'b01;
    tick(12);
    check_eq("t3_no_done_on_stale_valid", 64'(done_cnt), 64'(nd));
    check_eq("t3_grant_held", 64'(grant), 64'(2'b01));
    man_valid = 1'b0;
    tick(1);
    man_valid = 1'b1;
    man_X = i2osp_model(32'hD00D_0004);
    tick(1);
    man_valid = 1'b0;
    wait_done(nd + 1, "t3b_done_timeout");
    req = '0;
    tick(1);
    man_mode = 1'b0;

    // Reset during WAIT
    auto_mode = 1'b0;
    req_x[W-1:0] = 32'hEEEE_0005;
    nd = done_cnt;
    e0 = err_cnt;
    req = 2'b01;
    tick(4);
    reset = 1'b1;
    #1;
    check_eq("t4_core_reset_during_reset", 64'(core_reset), 64'(1));
    tick(1);
    check_eq("t4_grant_after_reset", 64'(grant), 64'(0));
    check_eq("t4_core_x_after_reset", 64'(core_x), 64'(0));
    check_eq("t4_core_ready_after_reset", 64'(core_ready), 64'(0));
    reset = 1'b0;
    req = '0;
    tick(3);
    check_eq("t4_no_done", 64'(done_cnt), 64'(nd));
    check_eq("t4_no_err", 64'(err_cnt), 64'(e0));
    auto_mode = 1'b1;
    req_x[2*W-1:W] = 32'hF00F_0006;
    push_exp(2'b10, 32'hF00F_0006);
    req = 2'b10;
    wait_done(nd + 1, "t4_done_timeout");
    req = '0;

    // Requester drops mid-WAIT, other requester served next
    lat = 8;
    req_x = {32'h1111_2222, 32'h3333_4444};
    push_exp(2'b10, 32'h1111_2222);
    push_exp(2'b01, 32'h3333_4444);
    nd = done_cnt;
    req = 2'b10;
    tick(4);
    req = 2'b01;
    wait_done(nd + 2, "t5_done_timeout");
    req = '0;

    // Core never answers
    lat = 3;
    auto_mode = 1'b0;
    req_x[W-1:0] = 32'h7777_0007;
    e0 = err_cnt;
    r0 = rdy_cnt;
    nd = done_cnt;
    req = 2'b01;
`ifdef I2OSP_TIMEOUT_EN
    for (int k = 0; k < 40 && err_cnt == e0; k++) tick(1);
    check_eq("t6_err_count", 64'(err_cnt - e0), 64'(1));
    check_eq("t6_err_onehot", 64'(err_val), 64'(2'b01));
    check_eq("t6_err_delay", 64'(err_cyc - rdy_cyc), 64'(16));
    check_eq("t6_core_reset_on_abort", 64'(err_rst), 64'(1));
    req = '0;
    tick(1);
    check_eq("t6_grant_after_abort", 64'(grant), 64'(0));
    check_eq("t6_core_reset_after_abort", 64'(core_reset), 64'(0));
    check_eq("t6_res_data_kept", 64'(res_data), 64'(i2osp_model(32'h3333_4444)));
`else
    tick(40);
    check_eq("t6_no_err", 64'(err_cnt - e0), 64'(0));
    check_eq("t6_still_granted", 64'(grant), 64'(2'b01));
    check_eq("t6_single_ready", 64'(rdy_cnt - r0), 64'(1));
    check_eq("t6_no_done", 64'(done_cnt), 64'(nd));
    reset = 1'b1;
    req = '0;
    tick(1);
    reset = 1'b0;
`endif
    auto_mode = 1'b1;
    tick(2);
    check_eq("final_sb_empty", 64'(sb.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
